// File: rtl/slt_seq_pkg.sv
// slt_seq_pkg -- shared definitions for the sequential set-less-than unit.
//   state_t      : FSM encoding (IDLE/BUSY/DONE)
//   chunk_legal  : legality of a WIDTH/CHUNK pairing
//   idx_width    : bit width of the slice index (clog2 of slice count, min 1)
// Optional feature macro used by the files that import this package:
// SLT_SEQ_FLAGS_EN.
package slt_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic bit chunk_legal(input int width, input int chunk);
      return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

   function automatic int idx_width(input int nchunk);
      return (nchunk <= 1) ? 1 : $clog2(nchunk);
   endfunction

endpackage

// File: rtl/slt_seq_unit_if.sv
// slt_seq_unit_if -- request/response bundle for slt_seq_unit.
//   in_valid/in_ready/in_a/in_b/in_signed : request handshake and operands
//   out_valid/out_ready/result            : response handshake and result
//   eq/ovf                                : extra flags, only when SLT_SEQ_FLAGS_EN is defined
// master = producer/consumer side, slave = the unit.
interface slt_seq_unit_if
   import slt_seq_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_signed;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
`ifdef SLT_SEQ_FLAGS_EN
   logic             eq;
   logic             ovf;
`endif

   modport master (
      output in_valid, in_a, in_b, in_signed, out_ready,
      input  in_ready, out_valid, result
`ifdef SLT_SEQ_FLAGS_EN
      , input eq, ovf
`endif
   );

   modport slave (
      input  in_valid, in_a, in_b, in_signed, out_ready,
      output in_ready, out_valid, result
`ifdef SLT_SEQ_FLAGS_EN
      , output eq, ovf
`endif
   );

endinterface

// File: rtl/slt_slice_sub.sv
// slt_slice_sub -- one CHUNK-bit slice of A + ~B + cin.
//   a, nb : operand A slice and inverted operand B slice
//   cin   : carry into the slice
//   sum   : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (used for signed overflow)
module slt_slice_sub
   import slt_seq_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] nb,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             cmsb
);
   logic [CHUNK:0] full;

   assign full = {1'b0, a} + {1'b0, nb} + {{CHUNK{1'b0}}, cin};
   assign sum  = full[CHUNK-1:0];
   assign cout = full[CHUNK];
   // The MSB sum bit is a ^ nb ^ carry-in, so the carry in is recoverable.
   assign cmsb = sum[CHUNK-1] ^ a[CHUNK-1] ^ nb[CHUNK-1];

endmodule

// File: rtl/slt_seq_unit.sv
// slt_seq_unit -- multi-cycle set-less-than, one CHUNK-bit slice per cycle.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slt_seq_unit_if.slave (request, response, optional flags)
// Optional feature: SLT_SEQ_FLAGS_EN adds eq (A == B) and ovf (signed
// overflow of A-B), registered with the result.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// BUSY  | fetch slice operands, then one slice per cycle LSB upward
// DONE  | out_valid=1, result held until out_ready
module slt_seq_unit
   import slt_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic           clk,
   input logic           reset,
   slt_seq_unit_if.slave bus
);
   localparam int            NCHUNK   = WIDTH / CHUNK;
   localparam int            IW       = idx_width(NCHUNK);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("slt_seq_unit: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, nb_q;
   logic [CHUNK-1:0] sl_a_q, sl_nb_q;
   logic             signed_q, carry_q, fetched_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] res_q;

   logic [CHUNK-1:0] sl_sum;
   logic             sl_cout, sl_cmsb;
   logic             last_slice, ovf_now, slt_bit;

   slt_slice_sub #(.CHUNK(CHUNK)) u_slice (
      .a    (sl_a_q),
      .nb   (sl_nb_q),
      .cin  (carry_q),
      .sum  (sl_sum),
      .cout (sl_cout),
      .cmsb (sl_cmsb)
   );

   assign last_slice = fetched_q && (idx_q == LAST_IDX);
   assign ovf_now    = sl_cmsb ^ sl_cout;
   assign slt_bit    = signed_q ? (sl_sum[CHUNK-1] ^ ovf_now) : ~sl_cout;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid) state_d = BUSY;
         BUSY:    if (last_slice)   state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.result    = res_q;
   end

   // Slice operands are registered from the shift registers, so the first
   // BUSY cycle only fetches slice 0; the adder then runs flop to flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q       <= '0;
         nb_q      <= '0;
         sl_a_q    <= '0;
         sl_nb_q   <= '0;
         signed_q  <= 1'b0;
         carry_q   <= 1'b1;
         fetched_q <= 1'b0;
         idx_q     <= '0;
         res_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q       <= bus.in_a;
                  nb_q      <= ~bus.in_b;
                  signed_q  <= bus.in_signed;
                  carry_q   <= 1'b1;
                  idx_q     <= '0;
                  fetched_q <= 1'b0;
               end
            end
            BUSY: begin
               sl_a_q    <= a_q[CHUNK-1:0];
               sl_nb_q   <= nb_q[CHUNK-1:0];
               a_q       <= a_q >> CHUNK;
               nb_q      <= nb_q >> CHUNK;
               fetched_q <= 1'b1;
               if (fetched_q) begin
                  carry_q <= sl_cout;
                  idx_q   <= idx_q + 1'b1;
                  if (last_slice) res_q <= {{(WIDTH-1){1'b0}}, slt_bit};
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SLT_SEQ_FLAGS_EN
   logic zacc_q, eq_q, ovf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         zacc_q <= 1'b0;
         eq_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state_q == IDLE && bus.in_valid) begin
         zacc_q <= 1'b1;
      end else if (state_q == BUSY && fetched_q) begin
         zacc_q <= zacc_q & (sl_sum == '0);
         if (last_slice) begin
            eq_q  <= zacc_q & (sl_sum == '0);
            ovf_q <= ovf_now;
         end
      end
   end

   assign bus.eq  = eq_q;
   assign bus.ovf = ovf_q;
`else
   // Only the sum MSB matters without the eq flag.
   logic unused_sum;
   assign unused_sum = ^sl_sum;
`endif

endmodule

// File: tb/tb_slt_seq_unit.sv
// tb_slt_seq_unit -- directed bench for slt_seq_unit with a result scoreboard.
// CHUNK is a bench parameter (8 or 32); SLT_SEQ_FLAGS_EN enables eq/ovf checks.
module tb_slt_seq_unit;
   localparam int W = 32;
   parameter int CHUNK = 8;
   localparam int NCHUNK = W / CHUNK;

   typedef struct {
      logic [W-1:0] res;
      logic         eq;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   slt_seq_unit_if #(.WIDTH(W)) bus ();

   slt_seq_unit #(.WIDTH(W), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t         e;
      logic [W-1:0] d;
      d      = a - b;
      e.res  = '0;
      e.res[0] = s ? ($signed(a) < $signed(b)) : (a < b);
      e.eq   = (a == b);
      e.ovf  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
      return e;
   endfunction

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int stall);
      exp_t e;
      int   cyc;
      sb.push_back(model(a, b, s));
      cyc = 0;
      while (bus.in_ready !== 1'b1 && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      chk({tag, "_rdy"}, W'(bus.in_ready), W'(1));
      bus.in_a = a; bus.in_b = b; bus.in_signed = s; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_a = $urandom; bus.in_b = $urandom; bus.in_signed = ~s;
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 100) begin
         chk({tag, "_busy_rdy"}, W'(bus.in_ready), W'(0));
         @(posedge clk); #1; cyc++;
      end
      chk({tag, "_lat"}, W'(cyc), W'(NCHUNK + 1));
      e = sb.pop_front();
      for (int i = 0; i < stall; i++) begin
         chk({tag, "_hold_vld"}, W'(bus.out_valid), W'(1));
         chk({tag, "_hold_res"}, bus.result, e.res);
         chk({tag, "_hold_rdy"}, W'(bus.in_ready), W'(0));
         @(posedge clk); #1;
      end
      chk({tag, "_res"}, bus.result, e.res);
`ifdef SLT_SEQ_FLAGS_EN
      chk({tag, "_eq"}, W'(bus.eq), W'(e.eq));
      chk({tag, "_ovf"}, W'(bus.ovf), W'(e.ovf));
`endif
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "_post_vld"}, W'(bus.out_valid), W'(0));
      chk({tag, "_post_rdy"}, W'(bus.in_ready), W'(1));
      chk({tag, "_post_res"}, bus.result, e.res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_signed = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", W'(bus.in_ready), W'(1));
      chk("rst_vld", W'(bus.out_valid), W'(0));
      chk("rst_res", bus.result, '0);
`ifdef SLT_SEQ_FLAGS_EN
      chk("rst_eq", W'(bus.eq), W'(0));
      chk("rst_ovf", W'(bus.ovf), W'(0));
`endif
      reset = 1'b0;
      @(posedge clk); #1;

      run_op("u5lt7", 32'd5, 32'd7, 1'b0, 0);
      chk("u5lt7_const", bus.result, 32'h1);
      run_op("u7lt5", 32'd7, 32'd5, 1'b0, 0);
      chk("u7lt5_const", bus.result, 32'h0);
      run_op("s_m1_1", 32'hFFFF_FFFF, 32'd1, 1'b1, 0);
      chk("s_m1_1_const", bus.result, 32'h1);
      run_op("u_m1_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      chk("u_m1_1_const", bus.result, 32'h0);
      run_op("s_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
      chk("s_min_max_const", bus.result, 32'h1);
`ifdef SLT_SEQ_FLAGS_EN
      chk("s_min_max_ovf_const", W'(bus.ovf), W'(1));
      chk("s_min_max_eq_const", W'(bus.eq), W'(0));
`endif
      run_op("s_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);
      chk("s_max_min_const", bus.result, 32'h0);
      run_op("bp_3_9", 32'd3, 32'd9, 1'b0, 10);
      chk("bp_3_9_const", bus.result, 32'h1);
      run_op("zero_u", 32'd0, 32'd0, 1'b0, 0);
      run_op("zero_s", 32'd0, 32'd0, 1'b1, 0);
      run_op("eq_s", 32'h1234_5678, 32'h1234_5678, 1'b1, 0);
      chk("eq_s_const", bus.result, 32'h0);
`ifdef SLT_SEQ_FLAGS_EN
      chk("eq_s_eq_const", W'(bus.eq), W'(1));
`endif
      run_op("eq_u", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2);
      run_op("s_neg_neg", 32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1, 0);
      run_op("u_hi_lo", 32'h8000_0001, 32'h0000_0002, 1'b0, 0);
      run_op("u_carry", 32'h0001_0000, 32'h0000_FFFF, 1'b0, 0);
      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] ra, rb;
         ra = $urandom;
         rb = (i == 3) ? ra : $urandom;
         run_op("rand", ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      // Reset during BUSY: no result may survive or appear afterward.
      run_op("pre_rst", 32'd5, 32'd7, 1'b0, 0);
      bus.in_a = 32'd2; bus.in_b = 32'd9; bus.in_signed = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_busy_rdy", W'(bus.in_ready), W'(1));
      chk("rst_busy_vld", W'(bus.out_valid), W'(0));
      chk("rst_busy_res", bus.result, '0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("rst_busy_no_stale", W'(bus.out_valid), W'(0));
      end
      run_op("post_rst", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
